fsm_cmd_arbiter: RTL

Round-robin arbiter that shares the 3-bit command input of the downstream control FSM among several requesters. It grants one requester at a time, latches that requester's command and drives it to the FSM for the life of the grant. Every grant is bounded by a hold timeout, and all outputs are forced to a safe zero value outside a grant. The arbiter's own state machine is fully encoded: any illegal state recovers to IDLE and is flagged.

---
 rtl/fsm_ctrl_pkg.sv | 18 +
 rtl/fsm_cmd_arbiter_if.sv | 26 ++
 rtl/fsm_cmd_arbiter_rr_pick.sv | 38 +++
 rtl/fsm_cmd_arbiter.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/fsm_ctrl_pkg.sv
// Shared types and constants for the control-FSM command path.
// Holds the arbiter state encoding (one-hot, 3-bit), the default command
// width and the safe command value driven whenever no grant is active.
package fsm_ctrl_pkg;

    // Only these three encodings are legal; anything else is recovered.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'b001,
        ST_GRANT   = 3'b010,
        ST_RELEASE = 3'b100
    } state_t;

    localparam int CMD_W_DFLT = 3;
    localparam logic [CMD_W_DFLT-1:0] CMD_SAFE = '0;

    localparam int CNT_W = 8;

endpackage

// File: rtl/fsm_cmd_arbiter_if.sv
// Requester/FSM-side bundle of the command arbiter.
// master: requester side (drives req/cmd, observes grant and status).
// slave:  arbiter side (samples req/cmd, drives grant, command and status).
interface fsm_cmd_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int CMD_W   = 3
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*CMD_W-1:0] cmd;
    logic [NUM_REQ-1:0]       gnt;
    logic [CMD_W-1:0]         fsm_cmd;
    logic                     fsm_cmd_valid;
    logic                     busy;
    logic                     timeout;
    logic                     illegal_state;

    modport master (
        output req, cmd,
        input  gnt, fsm_cmd, fsm_cmd_valid, busy, timeout, illegal_state
    );

    modport slave (
        input  req, cmd,
        output gnt, fsm_cmd, fsm_cmd_valid, busy, timeout, illegal_state
    );
endinterface

// File: rtl/fsm_cmd_arbiter_rr_pick.sv
// Round-robin priority search: first set req bit at or above ptr, wrapping.
// Latency: purely combinational.
// Ports: req/ptr in; any (some request pending) and winner index out.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] winner
);
    // One extra bit so ptr + k cannot overflow before the modulo fold.
    localparam int SW = IDX_W + 1;

    logic          found;
    logic [SW-1:0] sum;
    logic [IDX_W-1:0] sel;

    always_comb begin
        any    = |req;
        winner = '0;
        found  = 1'b0;
        sum    = '0;
        sel    = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + SW'(k);
            if (sum >= SW'(N)) begin
                sum = sum - SW'(N);
            end
            sel = sum[IDX_W-1:0];
            if (!found && req[sel]) begin
                winner = sel;
                found  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fsm_cmd_arbiter.sv
// Round-robin arbiter sharing the control FSM command input among requesters.
// Latency: req seen in IDLE at edge N -> grant/command valid after edge N; 2 dead cycles between grants.
// Backpressure: level requests wait in place; a grant ends on req drop or after MAX_HOLD cycles.
// Ports: clk, rst_n (async active-low), bus (slave side: req/cmd in; gnt, fsm_cmd,
// fsm_cmd_valid, busy, timeout, sticky illegal_state out).
module fsm_cmd_arbiter
    import fsm_ctrl_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int CMD_W    = CMD_W_DFLT,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    fsm_cmd_arbiter_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REQ - 1);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic [IDX_W-1:0] winner, winner_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CMD_W-1:0] cmd_reg, cmd_reg_nxt;
    logic             to_flag, to_flag_nxt;
    logic             illegal_q, illegal_nxt;

    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;

    logic [NUM_REQ-1:0] gnt_o;
    logic [CMD_W-1:0]   fsm_cmd_o;
    logic               valid_o;
    logic               busy_o;
    logic               timeout_o;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req    (bus.req),
        .ptr    (ptr),
        .any    (pick_any),
        .winner (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            winner    <= '0;
            cnt       <= '0;
            cmd_reg   <= '0;
            to_flag   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            winner    <= winner_nxt;
            cnt       <= cnt_nxt;
            cmd_reg   <= cmd_reg_nxt;
            to_flag   <= to_flag_nxt;
            illegal_q <= illegal_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        winner_nxt  = winner;
        cnt_nxt     = cnt;
        cmd_reg_nxt = cmd_reg;
        to_flag_nxt = to_flag;
        illegal_nxt = illegal_q;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    state_nxt   = ST_GRANT;
                    winner_nxt  = pick_idx;
                    // Command is captured once here; later cmd changes are ignored.
                    cmd_reg_nxt = bus.cmd[int'(pick_idx)*CMD_W +: CMD_W];
                    cnt_nxt     = CNT_W'(1);
                    to_flag_nxt = 1'b0;
                end
            end
            ST_GRANT: begin
                // A req drop wins over the hold limit on the same edge.
                if (!bus.req[winner]) begin
                    state_nxt   = ST_RELEASE;
                    to_flag_nxt = 1'b0;
                end else if (cnt == HOLD_LIMIT) begin
                    state_nxt   = ST_RELEASE;
                    to_flag_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                state_nxt   = ST_IDLE;
                to_flag_nxt = 1'b0;
                ptr_nxt     = (winner == LAST_IDX) ? '0 : winner + IDX_W'(1);
            end
            default: begin
                // Corrupted encoding: recover, leave ptr alone, latch the flag.
                state_nxt   = ST_IDLE;
                to_flag_nxt = 1'b0;
                illegal_nxt = 1'b1;
            end
        endcase
    end

    // Outputs decode only the state register and other flops, so nothing
    // combinational reaches them from req/cmd. Exact-match decode keeps an
    // illegal encoding at all-zero outputs.
    always_comb begin
        gnt_o     = '0;
        fsm_cmd_o = CMD_W'(CMD_SAFE);
        valid_o   = 1'b0;
        busy_o    = 1'b0;
        timeout_o = 1'b0;
        if (state == ST_GRANT) begin
            gnt_o[winner] = 1'b1;
            fsm_cmd_o     = cmd_reg;
            valid_o       = 1'b1;
            busy_o        = 1'b1;
        end else if (state == ST_RELEASE) begin
            busy_o    = 1'b1;
            timeout_o = to_flag;
        end
    end

    assign bus.gnt           = gnt_o;
    assign bus.fsm_cmd       = fsm_cmd_o;
    assign bus.fsm_cmd_valid = valid_o;
    assign bus.busy          = busy_o;
    assign bus.timeout       = timeout_o;
    assign bus.illegal_state = illegal_q;

endmodule
